corescore_stream_uart: RTL
==========================

CORESCORE_STREAM_UART -- requirements
Module: corescore_stream_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, is the number of i_clk cycles per UART bit and SHALL be legal only for values >= 2.
REQ-002 Parameter FIFO_AW, default 4, is the log2 of the byte FIFO depth (16 entries at default).
REQ-003 Port i_clk, input, 1 bit: the single clock.
REQ-004 Port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port i_tdata, input, 8 bits: stream byte from corescorecore.
REQ-006 Port i_tlast, input, 1 bit: marks the last byte of a message.
REQ-007 Port i_tvalid, input, 1 bit: stream valid.
REQ-008 Port o_tready, output, 1 bit: stream ready.
REQ-009 Port o_uart_tx, output, 1 bit: 8N1 serial line, idle high.
REQ-010 Port o_eom, output, 1 bit: one-cycle pulse after a tlast-tagged byte finishes its stop bit.
REQ-011 Port o_level, output, FIFO_AW+1 bits: current FIFO occupancy.

Function
REQ-012 A byte SHALL be accepted on every rising edge where i_tvalid and o_tready are both high; {i_tlast, i_tdata} SHALL be written as one 9-bit FIFO entry.
REQ-013 o_tready SHALL be a registered output, high exactly when o_level < 2**FIFO_AW after the edge; it SHALL NOT depend combinationally on i_tvalid.
REQ-014 Write and pop on the same edge SHALL leave o_level unchanged; when the FIFO is full, a pop SHALL raise o_tready on the following edge.
REQ-015 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-016 IDLE -> START SHALL occur on an edge where the FIFO is non-empty; the entry SHALL be popped on that same edge.
REQ-017 START, each DATA bit and STOP SHALL each hold o_uart_tx for exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded with CLKS_PER_BIT-1.
REQ-018 Data bits SHALL be sent LSB first through an 8-bit shift register and a 3-bit bit index; the DATA -> STOP transition SHALL occur after bit 7.
REQ-019 START SHALL drive o_uart_tx = 0; STOP and IDLE SHALL drive o_uart_tx = 1.
REQ-020 o_uart_tx SHALL be a register output with no glitches.
REQ-021 Latency: a byte accepted into an empty FIFO at edge n with the FSM in IDLE SHALL drive o_uart_tx low from edge n+1.
REQ-022 One frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-023 At the end of STOP, if the FIFO is non-empty, the FSM SHALL go directly to START (pop on that edge) with zero idle cycles; otherwise it SHALL go to IDLE.
REQ-024 o_eom SHALL pulse high for exactly one cycle on the edge that ends STOP, if the transmitted entry had tlast = 1.
REQ-025 The FIFO read and write pointers SHALL be FIFO_AW bits wide and wrap modulo 2**FIFO_AW.
REQ-026 o_level SHALL be maintained as a separate counter so that full and empty are unambiguous.

Reset
REQ-027 While i_rst is high, the block SHALL hold o_tready = 0, o_uart_tx = 1, o_eom = 0, o_level = 0, FSM = IDLE, pointers = 0 and the bit counter = 0.
REQ-028 A reset mid-frame SHALL abandon the frame (o_uart_tx = 1 on the next edge) and discard all FIFO contents.
REQ-029 After reset falls, o_tready SHALL rise on the first edge.

Structure
REQ-030 Package corescore_uart_pkg SHALL hold the FSM state typedef and the constant FRAME_BITS = 10.
REQ-031 The FIFO SHALL be a sub-module, corescore_byte_fifo (width and depth parameters, registered level, full and empty outputs).
REQ-032 The serializer FSM, baud counter and shift register SHALL remain in the top module.

Verification (CLKS_PER_BIT=4, FIFO_AW=2)
REQ-033 Single byte 0x55 with tlast=0: the line SHALL read 0,1,0,1,0,1,0,1,0,1 with each bit 4 cycles long; tx low starts one edge after acceptance; o_eom stays 0.
REQ-034 Two bytes 0xA3 then 0x0F, both accepted while busy: frames SHALL be back-to-back over 80 cycles with no idle gap between the frames.
REQ-035 Hold i_tvalid high for 6 bytes: o_tready SHALL fall after 4 accepted bytes plus the first pop (5 accepted in total), and SHALL rise one edge after each subsequent pop; all 6 bytes SHALL be transmitted in order.
REQ-036 Send 0x0A with tlast=1: o_eom SHALL pulse exactly once, 40 cycles after the start bit begins.
REQ-037 Assert i_rst during DATA bit 3 with 2 bytes queued: o_uart_tx SHALL be 1 next edge and o_level = 0; after release, a new byte 0x31 SHALL transmit correctly with no remnants of the abandoned bytes.

Source files
------------

// File: rtl/corescore_uart_pkg.sv
// Shared definitions for the corescore stream-to-UART bridge.
//   uart_state_e : serializer FSM states
//   FRAME_BITS   : line bits per 8N1 frame (start + 8 data + stop)
//   DATA_BITS    : payload bits per frame
package corescore_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/corescore_byte_fifo.sv
// Synchronous FIFO with a separate occupancy counter and a registered
// write-ready flag.
//   clk, rst     : clock, synchronous active-high reset
//   wr_en        : write strobe (caller guarantees FIFO is not full)
//   wr_data      : entry to store
//   rd_en        : pop strobe (ignored when empty)
//   rd_data      : entry at the read pointer (valid when not empty)
//   level        : registered occupancy, 0..2**AW
//   full, empty  : decoded from level
//   wr_ready     : registered, high when level after the edge is below depth
module corescore_byte_fifo #(
  parameter int WIDTH = 9,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty,
  output logic             wr_ready
);

  localparam int unsigned DEPTH     = 2**AW;
  localparam logic [AW:0] DEPTH_L   = DEPTH[AW:0];
  localparam int unsigned ONE       = 1;
  localparam logic [AW-1:0] PTR_ONE = ONE[AW-1:0];
  localparam logic [AW:0]   LVL_ONE = ONE[AW:0];

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic [AW:0]      level_next_s;
  logic             wr_ready_r;
  logic             do_rd_s;

  assign do_rd_s  = rd_en & ~empty;
  assign rd_data  = mem_r[rd_ptr_r];
  assign level    = level_r;
  assign full     = (level_r == DEPTH_L);
  assign empty    = (level_r == {(AW+1){1'b0}});
  assign wr_ready = wr_ready_r;

  // Occupancy after this edge; simultaneous write and pop cancel out.
  always_comb begin
    level_next_s = level_r;
    case ({wr_en, do_rd_s})
      2'b10:   level_next_s = level_r + LVL_ONE;
      2'b01:   level_next_s = level_r - LVL_ONE;
      default: level_next_s = level_r;
    endcase
  end

  // Storage array; contents are meaningless until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, level and ready flag; pointers wrap naturally at 2**AW.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= {(AW+1){1'b0}};
      wr_ready_r <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r    <= level_next_s;
      wr_ready_r <= (level_next_s != DEPTH_L);
    end
  end

endmodule

// File: rtl/corescore_stream_uart.sv
// Byte stream to 8N1 UART transmitter with an input FIFO.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_tdata      : stream byte
//   i_tlast      : last byte of a message
//   i_tvalid     : stream valid
//   o_tready     : registered stream ready (FIFO not full)
//   o_uart_tx    : registered serial line, idle high
//   o_eom        : one-cycle pulse when a tlast byte finishes its stop bit
//   o_level      : FIFO occupancy
// CLKS_PER_BIT must be at least 2.
module corescore_stream_uart
  import corescore_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             o_tready,
  output logic             o_uart_tx,
  output logic             o_eom,
  output logic [FIFO_AW:0] o_level
);

  localparam int CNT_W                  = $clog2(CLKS_PER_BIT);
  localparam int unsigned RELOAD        = CLKS_PER_BIT - 1;
  localparam int unsigned ONE           = 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = RELOAD[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE  = ONE[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  uart_state_e          state_r, state_next_s;
  logic [CNT_W-1:0]     cnt_r, cnt_next_s;
  logic [2:0]           bit_r, bit_next_s;
  logic [DATA_BITS-1:0] shift_r, shift_next_s;
  logic                 last_r, last_next_s;
  logic                 tx_r, tx_next_s;
  logic                 eom_r, eom_next_s;
  logic                 pop_s;
  logic                 accept_s;
  logic [8:0]           fifo_rdata_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 fifo_ready_s;

  // The full term is redundant with the registered ready but keeps a write
  // into a full FIFO impossible by construction.
  assign accept_s = i_tvalid & fifo_ready_s & ~fifo_full_s;

  corescore_byte_fifo #(
    .WIDTH (9),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .wr_en    (accept_s),
    .wr_data  ({i_tlast, i_tdata}),
    .rd_en    (pop_s),
    .rd_data  (fifo_rdata_s),
    .level    (o_level),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .wr_ready (fifo_ready_s)
  );

  assign o_tready  = fifo_ready_s;
  assign o_uart_tx = tx_r;
  assign o_eom     = eom_r;

  // Serializer state, baud counter, shift register and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      bit_r   <= 3'd0;
      shift_r <= {DATA_BITS{1'b0}};
      last_r  <= 1'b0;
      tx_r    <= 1'b1;
      eom_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      bit_r   <= bit_next_s;
      shift_r <= shift_next_s;
      last_r  <= last_next_s;
      tx_r    <= tx_next_s;
      eom_r   <= eom_next_s;
    end
  end

  // Next-state logic; a pop loads the shift register on the same edge so
  // the start bit appears one edge after the FIFO turns non-empty.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    bit_next_s   = bit_r;
    shift_next_s = shift_r;
    last_next_s  = last_r;
    pop_s        = 1'b0;
    eom_next_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          state_next_s = START;
          pop_s        = 1'b1;
          cnt_next_s   = CNT_LOAD;
          shift_next_s = fifo_rdata_s[7:0];
          last_next_s  = fifo_rdata_s[8];
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == CNT_ZERO) begin
          state_next_s = DATA;
          cnt_next_s   = CNT_LOAD;
          bit_next_s   = 3'd0;
        end else begin
          cnt_next_s = cnt_r - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == CNT_ZERO) begin
          cnt_next_s = CNT_LOAD;
          if (bit_r == 3'd7) begin
            state_next_s = STOP;
            bit_next_s   = 3'd0;
          end else begin
            bit_next_s   = bit_r + 3'd1;
            shift_next_s = {1'b0, shift_r[DATA_BITS-1:1]};
          end
        end else begin
          cnt_next_s = cnt_r - CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_r == CNT_ZERO) begin
          eom_next_s = last_r;
          // Chain straight into the next frame when more data is waiting.
          if (!fifo_empty_s) begin
            state_next_s = START;
            pop_s        = 1'b1;
            cnt_next_s   = CNT_LOAD;
            shift_next_s = fifo_rdata_s[7:0];
            last_next_s  = fifo_rdata_s[8];
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          cnt_next_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Line level for the upcoming state, registered so the pin never glitches.
  always_comb begin
    tx_next_s = 1'b1;
    case (state_next_s)
      IDLE:    tx_next_s = 1'b1;
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = shift_next_s[0];
      STOP:    tx_next_s = 1'b1;
      default: tx_next_s = 1'b1;
    endcase
  end

endmodule
